mor1kx_ctrl_spr_access_cappuccino: RTL

Control-stage SPR bus master for the cappuccino pipeline. Takes the mfspr/mtspr operation held in the control stage, runs one transaction on the external SPR bus, and returns the `ctrl_mfspr_ack_o` / `ctrl_mtspr_ack_o` handshake that releases the control-stage stall, plus the read data for write-back. A cycle timeout guarantees the pipeline never hangs on an unmapped SPR.

---
 rtl/mor1kx_ctrl_spr_access_cappuccino.sv | 122 ++++++++++++
 1 files changed

// File: rtl/mor1kx_ctrl_spr_access_cappuccino.sv
// Control-stage SPR bus master: runs one mfspr/mtspr on the SPR bus and returns
// the stall-releasing ack. A strobe-cycle timeout forces completion on unmapped SPRs.
module mor1kx_ctrl_spr_access_cappuccino #(
  parameter int OPTION_OPERAND_WIDTH  = 32,
  parameter int OPTION_SPR_ADDR_WIDTH = 16,
  parameter int SPR_TIMEOUT           = 15
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             ctrl_op_mfspr_i,
  input  logic                             ctrl_op_mtspr_i,
  input  logic [OPTION_SPR_ADDR_WIDTH-1:0] ctrl_spr_adr_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0]  ctrl_rfb_i,
  input  logic                             padv_ctrl_i,
  input  logic                             pipeline_flush_i,
  output logic [OPTION_SPR_ADDR_WIDTH-1:0] spr_bus_addr_o,
  output logic                             spr_bus_we_o,
  output logic                             spr_bus_stb_o,
  output logic [OPTION_OPERAND_WIDTH-1:0]  spr_bus_dat_o,
  input  logic [OPTION_OPERAND_WIDTH-1:0]  spr_bus_dat_i,
  input  logic                             spr_bus_ack_i,
  output logic                             ctrl_mfspr_ack_o,
  output logic                             ctrl_mtspr_ack_o,
  output logic [OPTION_OPERAND_WIDTH-1:0]  mfspr_dat_o,
  output logic                             spr_timeout_o
);

  localparam int CW = $clog2(SPR_TIMEOUT + 1);
  localparam logic [CW-1:0] TMO = CW'(SPR_TIMEOUT);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  typedef struct packed {
    logic [OPTION_SPR_ADDR_WIDTH-1:0] adr;
    logic                             we;
    logic [OPTION_OPERAND_WIDTH-1:0]  dat;
  } spr_req_t;

  logic [1:0]    state;
  spr_req_t      req;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          tmo_hit;

  // Saturating count of strobe cycles including the current one.
  assign cnt_nxt = (cnt == TMO) ? cnt : cnt + CW'(1);
  assign tmo_hit = (cnt_nxt == TMO);

  assign spr_bus_addr_o = req.adr;
  assign spr_bus_we_o   = req.we;
  assign spr_bus_dat_o  = req.dat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      req              <= '0;
      cnt              <= '0;
      spr_bus_stb_o    <= 1'b0;
      ctrl_mfspr_ack_o <= 1'b0;
      ctrl_mtspr_ack_o <= 1'b0;
      mfspr_dat_o      <= '0;
      spr_timeout_o    <= 1'b0;
    end else if (pipeline_flush_i) begin
      // Abandon any in-flight access; a late bus ack lands in IDLE and is ignored.
      state            <= IDLE;
      spr_bus_stb_o    <= 1'b0;
      ctrl_mfspr_ack_o <= 1'b0;
      ctrl_mtspr_ack_o <= 1'b0;
      spr_timeout_o    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ctrl_op_mtspr_i | ctrl_op_mfspr_i) begin
            req.adr       <= ctrl_spr_adr_i;
            req.we        <= ctrl_op_mtspr_i;
            req.dat       <= ctrl_rfb_i;
            cnt           <= '0;
            spr_bus_stb_o <= 1'b1;
            state         <= ACCESS;
          end
        end
        ACCESS: begin
          if (spr_bus_ack_i) begin
            // Ack beats a simultaneous timeout.
            if (!req.we)
              mfspr_dat_o <= spr_bus_dat_i;
            spr_bus_stb_o    <= 1'b0;
            ctrl_mfspr_ack_o <= ~req.we;
            ctrl_mtspr_ack_o <= req.we;
            state            <= DONE;
          end else if (tmo_hit) begin
            mfspr_dat_o      <= '0;
            spr_timeout_o    <= 1'b1;
            spr_bus_stb_o    <= 1'b0;
            ctrl_mfspr_ack_o <= ~req.we;
            ctrl_mtspr_ack_o <= req.we;
            state            <= DONE;
          end
          cnt <= cnt_nxt;
        end
        DONE: begin
          if (padv_ctrl_i) begin
            ctrl_mfspr_ack_o <= 1'b0;
            ctrl_mtspr_ack_o <= 1'b0;
            spr_timeout_o    <= 1'b0;
            state            <= IDLE;
          end
        end
        default: begin
          spr_bus_stb_o    <= 1'b0;
          ctrl_mfspr_ack_o <= 1'b0;
          ctrl_mtspr_ack_o <= 1'b0;
          spr_timeout_o    <= 1'b0;
          state            <= IDLE;
        end
      endcase
    end
  end

endmodule
